// File: rtl/seg_scan6.sv
// Six-digit multiplexed 7-segment scanner with frame-synchronous digit update, leading-zero and anti-ghost blanking.
// Outputs lag the scan state by one cycle; no backpressure: load is always accepted and the last write before frame end wins.
module seg_scan6 #(
    parameter int DIV      = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       load,
    input  logic [3:0] d6,
    input  logic [3:0] d5,
    input  logic [3:0] d4,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [5:0] dp_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       pending,
    output logic       frame_done
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {DIGIT0, DIGIT1, DIGIT2, DIGIT3, DIGIT4, DIGIT5} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          cnt_wrap;
    logic          frame_end;
    logic [2:0]    idx;

    logic [23:0]   sh_dig, disp_dig, sh_dig_nxt;
    logic [5:0]    sh_dp, disp_dp, sh_dp_nxt;
    logic          pend_nxt;

    logic [3:0]    cur_digit;
    logic          cur_blank;
    logic          cur_dp;
    logic          zero_run;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            4'd10:   seg_decode = 7'h40;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    assign cnt_wrap  = (cnt == CW'(DIV - 1));
    assign frame_end = cnt_wrap && (state == DIGIT5);
    assign idx       = state;

    // Six-state digit ring; each state dwells DIV cycles
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        if (cnt_wrap) begin
            cnt_nxt = '0;
            case (state)
                DIGIT0:  state_nxt = DIGIT1;
                DIGIT1:  state_nxt = DIGIT2;
                DIGIT2:  state_nxt = DIGIT3;
                DIGIT3:  state_nxt = DIGIT4;
                DIGIT4:  state_nxt = DIGIT5;
                default: state_nxt = DIGIT0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= DIGIT0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A load on the frame-end edge flows straight through to disp
    always_comb begin
        sh_dig_nxt = load ? {d6, d5, d4, d3, d2, d1} : sh_dig;
        sh_dp_nxt  = load ? dp_in : sh_dp;
        pend_nxt   = load | pending;
    end

    always_comb begin
        cur_digit = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        zero_run  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            zero_run = zero_run & (disp_dig[20-4*i +: 4] == 4'd0);
            if (idx == 3'(i)) begin
                cur_digit = disp_dig[20-4*i +: 4];
                cur_blank = BLANK_LZ && zero_run && (i != 5);
                cur_dp    = disp_dp[5-i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sh_dig     <= '0;
            sh_dp      <= '0;
            disp_dig   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= 6'b111111;
            seg        <= '0;
            dp         <= 1'b0;
        end else begin
            sh_dig     <= sh_dig_nxt;
            sh_dp      <= sh_dp_nxt;
            frame_done <= frame_end;
            if (frame_end && pend_nxt) begin
                disp_dig <= sh_dig_nxt;
                disp_dp  <= sh_dp_nxt;
                pending  <= 1'b0;
            end else begin
                pending  <= pend_nxt;
            end
            an  <= (cnt == '0) ? 6'b111111 : ~(6'b100000 >> idx);
            seg <= cur_blank ? 7'h00 : seg_decode(cur_digit);
            dp  <= cur_dp;
        end
    end
endmodule

// File: tb/tb_seg_scan6.sv
module tb_seg_scan6;
    localparam int DIV   = 4;
    localparam int FRAME = 6 * DIV;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       load = 1'b0;
    logic [3:0] dig_in [6];
    logic [5:0] dp_in_v = '0;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, pend_a, pend_b, fd_a, fd_b;
    logic [5:0] an_a, an_b;

    int nchecks = 0;
    int nfail   = 0;
    bit chk_en  = 1'b0;

    seg_scan6 #(.DIV(DIV), .BLANK_LZ(1'b1)) dut_a (
        .CLK(CLK), .RST_n(RST_n), .load(load),
        .d6(dig_in[0]), .d5(dig_in[1]), .d4(dig_in[2]), .d3(dig_in[3]), .d2(dig_in[4]), .d1(dig_in[5]),
        .dp_in(dp_in_v), .seg(seg_a), .dp(dp_a), .an(an_a), .pending(pend_a), .frame_done(fd_a));

    seg_scan6 #(.DIV(DIV), .BLANK_LZ(1'b0)) dut_b (
        .CLK(CLK), .RST_n(RST_n), .load(load),
        .d6(dig_in[0]), .d5(dig_in[1]), .d4(dig_in[2]), .d3(dig_in[3]), .d2(dig_in[4]), .d1(dig_in[5]),
        .dp_in(dp_in_v), .seg(seg_b), .dp(dp_b), .an(an_b), .pending(pend_b), .frame_done(fd_b));

    always #5 CLK = ~CLK;

    function automatic logic [6:0] pat(input logic [3:0] v);
        case (v)
            4'd0: pat = 7'h3F;  4'd1: pat = 7'h06;  4'd2: pat = 7'h5B;  4'd3: pat = 7'h4F;
            4'd4: pat = 7'h66;  4'd5: pat = 7'h6D;  4'd6: pat = 7'h7D;  4'd7: pat = 7'h07;
            4'd8: pat = 7'h7F;  4'd9: pat = 7'h6F;  4'd10: pat = 7'h40;
            default: pat = 7'h00;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: scan position is simply time since reset modulo the frame
    int         t;
    logic [3:0] m_sh [6];
    logic [3:0] m_disp [6];
    logic [5:0] m_shdp, m_dispdp;
    bit         m_pend;
    logic [5:0] e_an;
    logic [6:0] e_seg_lz, e_seg_all;
    logic       e_dp, e_fd;

    always @(posedge CLK or negedge RST_n) begin : model
        int  pos, i, c;
        bit  zeros;
        if (!RST_n) begin
            t = 0;
            for (int k = 0; k < 6; k++) begin m_sh[k] = '0; m_disp[k] = '0; end
            m_shdp = '0; m_dispdp = '0; m_pend = 1'b0;
            e_an = 6'h3F; e_seg_lz = '0; e_seg_all = '0; e_dp = 1'b0; e_fd = 1'b0;
        end else begin
            pos = t % FRAME;
            i   = pos / DIV;
            c   = pos % DIV;
            e_an = (c == 0) ? 6'h3F : ~(6'd1 << (5 - i));
            zeros = 1'b1;
            for (int k = 0; k <= i; k++) if (m_disp[k] != 4'd0) zeros = 1'b0;
            e_seg_all = pat(m_disp[i]);
            e_seg_lz  = (zeros && i != 5) ? 7'h00 : e_seg_all;
            e_dp      = m_dispdp[5 - i];
            e_fd      = (pos == FRAME - 1);
            if (load) begin
                m_sh = dig_in; m_shdp = dp_in_v; m_pend = 1'b1;
            end
            if (e_fd && m_pend) begin
                m_disp = m_sh; m_dispdp = m_shdp; m_pend = 1'b0;
            end
            t++;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("an_lz", {26'd0, an_a}, {26'd0, e_an});
            chk("an_all", {26'd0, an_b}, {26'd0, e_an});
            chk("pending_lz", {31'd0, pend_a}, {31'd0, m_pend});
            chk("pending_all", {31'd0, pend_b}, {31'd0, m_pend});
            chk("frame_done", {31'd0, fd_a}, {31'd0, e_fd});
            chk("frame_done_all", {31'd0, fd_b}, {31'd0, e_fd});
            if (e_an != 6'h3F || !RST_n) begin
                chk("seg_lz", {25'd0, seg_a}, {25'd0, e_seg_lz});
                chk("seg_all", {25'd0, seg_b}, {25'd0, e_seg_all});
                chk("dp_lz", {31'd0, dp_a}, {31'd0, e_dp});
                chk("dp_all", {31'd0, dp_b}, {31'd0, e_dp});
            end
        end
    end

    logic [6:0] cap_a [6];
    logic [6:0] cap_b [6];
    logic       cap_dp [6];

    task automatic do_load(input logic [3:0] d0, d1v, d2v, d3v, d4v, d5v, input logic [5:0] dpv);
        dig_in[0] = d0; dig_in[1] = d1v; dig_in[2] = d2v;
        dig_in[3] = d3v; dig_in[4] = d4v; dig_in[5] = d5v;
        dp_in_v = dpv;
        load = 1'b1;
        @(negedge CLK);
        load = 1'b0;
        for (int k = 0; k < 6; k++) dig_in[k] = 4'($urandom);
        dp_in_v = 6'($urandom);
    endtask

    task automatic wait_fd();
        bit seen = 1'b0;
        for (int n = 0; n < 4 * FRAME && !seen; n++) begin
            @(negedge CLK);
            if (fd_a === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            nchecks++; nfail++;
            $display("FAIL wait_frame_done: got no pulse expected pulse within %0d cycles", 4 * FRAME);
        end
    endtask

    // Records one full frame of outputs, starting at the negedge after a frame end
    task automatic capture();
        for (int k = 0; k < 6; k++) begin cap_a[k] = 7'h7F; cap_b[k] = 7'h7F; cap_dp[k] = 1'bx; end
        for (int n = 0; n < FRAME; n++) begin
            @(negedge CLK);
            for (int k = 0; k < 6; k++) begin
                if (an_a[5 - k] == 1'b0) begin
                    cap_a[k] = seg_a; cap_b[k] = seg_b; cap_dp[k] = dp_a;
                end
            end
        end
    endtask

    task automatic chk_frame(input string nm, input logic [41:0] exp_a, input logic [41:0] exp_b);
        for (int k = 0; k < 6; k++) begin
            chk({nm, "_lz"}, {25'd0, cap_a[k]}, {25'd0, exp_a[41 - 7*k -: 7]});
            chk({nm, "_all"}, {25'd0, cap_b[k]}, {25'd0, exp_b[41 - 7*k -: 7]});
        end
    endtask

    initial begin
        logic [5:0] an_seq [6];
        for (int k = 0; k < 6; k++) dig_in[k] = 4'd0;
        RST_n = 1'b1;
        #1 RST_n = 1'b0;
        chk_en = 1'b1;

        // Reset held with load toggling
        for (int n = 0; n < 6; n++) begin
            load = n[0];
            dig_in[5] = 4'(n + 1);
            @(negedge CLK);
            chk("rst_an", {26'd0, an_a}, 32'h3F);
            chk("rst_seg", {25'd0, seg_a}, 32'h0);
            chk("rst_pending", {31'd0, pend_a}, 32'h0);
        end
        load = 1'b0;
        RST_n = 1'b1;

        an_seq[0] = 6'h3F; an_seq[1] = 6'h1F; an_seq[2] = 6'h1F;
        an_seq[3] = 6'h1F; an_seq[4] = 6'h3F; an_seq[5] = 6'h2F;
        for (int n = 0; n < 6; n++) begin
            @(negedge CLK);
            chk("release_an", {26'd0, an_a}, {26'd0, an_seq[n]});
        end

        // Basic display with leading zeros
        do_load(4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 6'd0);
        chk("basic_pending_set", {31'd0, pend_a}, 32'h1);
        wait_fd();
        chk("basic_pending_clr", {31'd0, pend_a}, 32'h0);
        capture();
        chk_frame("basic", {7'h00, 7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66},
                           {7'h3F, 7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66});

        // All zeros
        do_load(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 6'd0);
        wait_fd();
        capture();
        chk_frame("zeros", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F},
                           {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});

        // Overwrite before frame end: last write wins
        wait_fd();
        repeat (5) @(negedge CLK);
        do_load(4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 6'd0);
        repeat (5) @(negedge CLK);
        do_load(4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 6'd0);
        wait_fd();
        capture();
        chk_frame("overwrite", {6{7'h5B}}, {6{7'h5B}});

        // Load landing exactly on the frame-end edge
        wait_fd();
        repeat (FRAME - 1) @(negedge CLK);
        do_load(4'd6, 4'd7, 4'd5, 4'd4, 4'd3, 4'd2, 6'd0);
        chk("coincident_frame_done", {31'd0, fd_a}, 32'h1);
        chk("coincident_pending", {31'd0, pend_a}, 32'h0);
        capture();
        chk_frame("coincident", {7'h7D, 7'h07, 7'h6D, 7'h66, 7'h4F, 7'h5B},
                                {7'h7D, 7'h07, 7'h6D, 7'h66, 7'h4F, 7'h5B});

        // Special codes and decimal point
        do_load(4'd10, 4'd11, 4'd15, 4'd9, 4'd8, 4'd0, 6'b000001);
        wait_fd();
        capture();
        chk_frame("codes", {7'h40, 7'h00, 7'h00, 7'h6F, 7'h7F, 7'h3F},
                           {7'h40, 7'h00, 7'h00, 7'h6F, 7'h7F, 7'h3F});
        for (int k = 0; k < 6; k++)
            chk("codes_dp", {31'd0, cap_dp[k]}, (k == 5) ? 32'h1 : 32'h0);

        // Randomized loads, zero-biased digits to exercise blanking
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                logic [3:0] r [6];
                for (int k = 0; k < 6; k++) r[k] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
                do_load(r[0], r[1], r[2], r[3], r[4], r[5], 6'($urandom));
            end else begin
                @(negedge CLK);
            end
        end

        // Reset mid-scan with data pending
        wait_fd();
        do_load(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 6'h3F);
        repeat (3 * DIV) @(negedge CLK);
        chk("midrst_pending_before", {31'd0, pend_a}, 32'h1);
        #2 RST_n = 1'b0;
        #1;
        chk("midrst_an", {26'd0, an_a}, 32'h3F);
        chk("midrst_seg", {25'd0, seg_a}, 32'h0);
        chk("midrst_dp", {31'd0, dp_a}, 32'h0);
        chk("midrst_pending", {31'd0, pend_a}, 32'h0);
        chk("midrst_frame_done", {31'd0, fd_a}, 32'h0);
        @(negedge CLK);
        RST_n = 1'b1;
        wait_fd();
        chk("postrst_pending", {31'd0, pend_a}, 32'h0);
        capture();
        chk_frame("postrst", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, {6{7'h3F}});

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule

// File: doc/seg_scan6.md
# seg_scan6

Six-digit multiplexed seven-segment display scanner for the bottle-filling controller. It receives the six BCD digit nibbles that the controller presents on its light outputs, plus per-digit decimal points. Digits are captured through a load strobe into a shadow register and copied into the display register only at frame boundaries, so a frame never shows a mix of old and new digits. It then time-multiplexes the digits onto one shared segment bus with common-anode digit selects, leading-zero blanking and anti-ghost blanking.

## Interface
- DIV, 1000: clock cycles per digit dwell window; legal range 2..65535.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 shows every digit.
- CLK  in  1  system clock; all logic on rising edge.
- RST_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; captures d6..d1 and dp_in.
- d6, d5, d4, d3, d2, d1  in  4 each  digit nibbles; d6 is the most significant digit.
- dp_in  in  6  decimal points; bit 5 belongs to d6 and bit 0 to d1.
- seg  out  7  segments {g,f,e,d,c,b,a}; active high.
- dp  out  1  decimal-point segment; active high.
- an  out  6  digit selects; active low; an[5] drives d6.
- pending  out  1  high while shadow data waits to be transferred.
- frame_done  out  1  one-cycle pulse at the end of each scan frame.

## Operation
- Registers:
  - shadow: 24-bit digit store plus 6-bit dp store.
  - disp: same width as shadow.
  - cnt: prescaler, 0..DIV-1.
  - idx: digit index, 0..5.
  - pending flag.
- Reset values:
  - cnt=0, idx=0.
  - shadow=0, disp=0.
  - pending=0, frame_done=0.
  - an=6'b111111, seg=0, dp=0.
- cnt increments every cycle. When cnt=DIV-1 it wraps to 0 and idx advances: 0→1→…→5→0.
- Scan order: idx 0 = d6 (an[5]), idx 1 = d5, …, idx 5 = d1 (an[0]).
- load=1: shadow ← {d6..d1, dp_in} and pending ← 1. If load is asserted again while pending=1, the new data overwrites shadow (last write wins).
- Frame end is the edge where cnt=DIV-1 and idx=5. At that edge:
  - If pending=1, disp ← shadow and pending ← 0.
  - frame_done is set to 1 for exactly the next cycle.
- load coincident with frame end: the incoming data is written to both shadow and disp, and pending ends 0.
- Decode table:
  - 0..9 use standard patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, {g..a}).
  - 10 shows a dash: seg=40.
  - 11..15 are blank: seg=00.
- Leading-zero blanking (BLANK_LZ=1):
  - A digit is blanked (seg=00) if it equals 0 and every more-significant digit in disp is also 0.
  - d1 is never blanked.
  - dp for a blanked digit still follows dp_in.
  - A value of 10..15 counts as nonzero.
- Anti-ghosting: in the output cycle corresponding to cnt=0 of every dwell window, an=111111. In the remaining DIV-1 cycles, only the active digit's an bit is 0.
- State machine: the cnt/idx pair forms a six-state ring (DIGIT0..DIGIT5), each state lasting DIV cycles, with no idle state. Scanning starts at the first edge after reset release.

## Timing
- seg, dp and an are registered from (cnt, idx, disp) and lag that state by one cycle.
  - First edge after RST_n rises: outputs reflect cnt=0, idx=0, so an=111111.
  - Second edge: an=011111, and seg shows disp d6, which is blank after reset because of leading-zero blanking.
- Load-to-display latency:
  - Minimum 1 cycle, when load lands on the frame-end edge.
  - Maximum 6·DIV cycles, plus one output-register cycle.
- Frame period: 6·DIV cycles. frame_done pulses once per frame.
- Reset asserted mid-frame: all registers return to their reset values immediately and asynchronously. Any pending data is lost.
- Inputs d*, dp_in are sampled only on load cycles and may change at any other time.

## Test plan
- Reset: hold RST_n=0 with load toggling → an=111111, seg=0, pending=0 throughout. Release → an follows 111111, then 011111 for 3 cycles, 111111, then 101111 (DIV=4).
- Basic display (DIV=4, BLANK_LZ=1): load d6..d1 = 0,0,1,2,3,4 → after the next frame end, d6 and d5 show seg=00; then 06, 5B, 4F, 66 appear on an[3..0] in turn; pending drops at the transfer edge.
- All zeros: load 0,0,0,0,0,0 → only d1 is lit, seg=3F. With BLANK_LZ=0, all six digits show 3F.
- Overwrite and boundary: load 111111 mid-frame, then 222222 before frame end → only the 2s are ever displayed. load coincident with the frame-end edge → new digits appear in the next frame and pending=0.
- Codes and dp: digits 10,11,15,9,8,0 with dp_in=6'b000001 → seg=40, 00, 00, 6F, 7F, 3F; dp=1 only while an[0]=0.
- Reset mid-scan: assert RST_n=0 during idx=3 with pending=1 → outputs return to reset values at once; after release, blank digits are shown and pending=0.
